// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - latency-configurable RV32I data memory responder with valid/ready request and response ports
// Optional misaligned-access trap: define DMEM_MISALIGN_TRAP_EN (default build force-aligns instead).
module data_mem_responder #(
  parameter int ADDR_W  = 32,
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_rdata,
  output logic              resp_err
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int OFF_W = IDX_W + 2;
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY - 1);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RESP} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               we_q, we_d;
  logic [2:0]         funct3_q, funct3_d;
  logic [OFF_W-1:0]   addr_q, addr_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [31:0]        rdata_q, rdata_d;
  logic               err_q, err_d;

  logic [31:0]        mem_q [DEPTH];

  logic [IDX_W-1:0]   idx;
  logic [1:0]         size;
  logic               illegal, misalign, acc_err;
  logic [1:0]         lane;
  logic [31:0]        word;
  logic [15:0]        sel;
  logic [31:0]        load_val;
  logic [31:0]        store_lanes;
  logic [3:0]         mask;
  logic               access, mem_we;

  // Upper address bits only alias the array; they are intentionally dropped.
  logic unused_addr_hi;
  assign unused_addr_hi = ^req_addr[ADDR_W-1:OFF_W];

  assign idx  = addr_q[OFF_W-1:2];
  assign size = funct3_q[1:0];
  assign word = mem_q[idx];

  always_comb begin
    illegal     = we_q ? (funct3_q[2] || size == 2'b11)
                       : (size == 2'b11 || (funct3_q[2] && funct3_q[1]));
`ifdef DMEM_MISALIGN_TRAP_EN
    misalign    = (size == 2'b01 && addr_q[0]) || (size == 2'b10 && addr_q[1:0] != 2'b00);
`else
    misalign    = 1'b0;
`endif
    acc_err     = illegal || misalign;
    case (size)
      2'b01:   lane = {addr_q[1], 1'b0};
      2'b10:   lane = 2'b00;
      default: lane = addr_q[1:0];
    endcase
    sel         = 16'(word >> {lane, 3'b000});
    case (funct3_q)
      3'b000:  load_val = {{24{sel[7]}}, sel[7:0]};
      3'b001:  load_val = {{16{sel[15]}}, sel};
      3'b010:  load_val = word;
      3'b100:  load_val = {24'd0, sel[7:0]};
      3'b101:  load_val = {16'd0, sel};
      default: load_val = 32'd0;
    endcase
    case (size)
      2'b00:   begin mask = 4'b0001 << lane; store_lanes = {4{wdata_q[7:0]}};  end
      2'b01:   begin mask = 4'b0011 << lane; store_lanes = {2{wdata_q[15:0]}}; end
      default: begin mask = 4'b1111;         store_lanes = wdata_q;            end
    endcase
  end

  assign access     = (state_q == S_BUSY) && (cnt_q == '0);
  assign mem_we     = access && we_q && !acc_err;
  assign req_ready  = (state_q == S_IDLE);
  assign resp_valid = (state_q == S_RESP);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    we_d     = we_q;
    funct3_d = funct3_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          state_d  = S_BUSY;
          cnt_d    = CNT_INIT;
          we_d     = req_we;
          funct3_d = req_funct3;
          addr_d   = req_addr[OFF_W-1:0];
          wdata_d  = req_wdata;
        end
      end
      S_BUSY: begin
        if (cnt_q == '0) begin
          state_d = S_RESP;
          err_d   = acc_err;
          rdata_d = (acc_err || we_q) ? 32'd0 : load_val;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_RESP: begin
        if (resp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      we_q     <= 1'b0;
      funct3_q <= 3'd0;
      addr_q   <= '0;
      wdata_q  <= 32'd0;
      rdata_q  <= 32'd0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      we_q     <= we_d;
      funct3_q <= funct3_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  // Array has no reset; a reset mid-BUSY leaves state_q IDLE so no write can commit.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (mask[b]) mem_q[idx][8*b +: 8] <= store_lanes[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// tb/tb_data_mem_responder.sv - scoreboard bench for data_mem_responder (directed cases plus modelled random traffic)
module tb_data_mem_responder;

  localparam int ADDR_W  = 32;
  localparam int DEPTH   = 256;
  localparam int LATENCY = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic              req_we = 1'b0;
  logic [2:0]        req_funct3 = 3'd0;
  logic [ADDR_W-1:0] req_addr = '0;
  logic [31:0]       req_wdata = 32'd0;
  logic              resp_valid;
  logic              resp_ready = 1'b1;
  logic [31:0]       resp_rdata;
  logic              resp_err;

  int vectors = 0;
  int miscompares = 0;
  logic [32:0] sb_q [$];
  logic [31:0] mdl [16];

`ifdef DMEM_MISALIGN_TRAP_EN
  localparam logic TRAP = 1'b1;
`else
  localparam logic TRAP = 1'b0;
`endif

  data_mem_responder #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .LATENCY(LATENCY)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  // Reference for the random region (words 0x40..0x7F); kept in its own word array.
  task automatic model_op(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wd, output logic [31:0] rd, output logic err);
    int wi, off;
    logic [31:0] w;
    logic [7:0]  b;
    logic [15:0] h;
    wi  = int'(addr[5:2]);
    off = int'(addr[1:0]);
    w   = mdl[wi];
    rd  = 32'd0;
    if (we) err = (f3 > 3'd2);
    else    err = (f3 == 3'd3 || f3 > 3'd5);
    if (TRAP && (f3 == 3'd1 || f3 == 3'd5) && off[0]) err = 1'b1;
    if (TRAP && f3 == 3'd2 && off != 0) err = 1'b1;
    if (f3 == 3'd1 || f3 == 3'd5) off = off & 2;
    if (f3 == 3'd2) off = 0;
    if (!err) begin
      if (we) begin
        if (f3 == 3'd0)      w[off*8 +: 8]  = wd[7:0];
        else if (f3 == 3'd1) w[off*8 +: 16] = wd[15:0];
        else                 w = wd;
        mdl[wi] = w;
      end else begin
        b = w[off*8 +: 8];
        h = w[off*8 +: 16];
        case (f3)
          3'd0:    rd = {{24{b[7]}}, b};
          3'd1:    rd = {{16{h[15]}}, h};
          3'd2:    rd = w;
          3'd4:    rd = {24'd0, b};
          default: rd = {16'd0, h};
        endcase
      end
    end
  endtask

  task automatic do_txn(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [31:0] exp_rd, input logic exp_err,
                        input int hold);
    int n;
    logic [32:0] exp;
    n = 0;
    while (!req_ready && n < 20) begin @(posedge clk); #1; n++; end
    if (!req_ready) begin check_eq("req_ready_timeout", 32'(req_ready), 32'd1); return; end
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    @(posedge clk); #1;
    req_valid = 1'b0;
    sb_q.push_back({exp_err, exp_rd});
    n = 0;
    while (!resp_valid && n < 20) begin @(posedge clk); #1; n++; end
    check_eq("latency", 32'(n), 32'(LATENCY));
    exp = sb_q.pop_front();
    if (!resp_valid) return;
    check_eq("rdata", resp_rdata, exp[31:0]);
    check_eq("err", 32'(resp_err), 32'(exp[32]));
    if (hold > 0) begin
      resp_ready = 1'b0;
      req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'd2; req_addr = 32'h10; req_wdata = 32'hFFFF_FFFF;
      repeat (hold) begin
        @(posedge clk); #1;
        check_eq("hold_valid", 32'(resp_valid), 32'd1);
        check_eq("hold_rdata", resp_rdata, exp[31:0]);
        check_eq("hold_err", 32'(resp_err), 32'(exp[32]));
        check_eq("hold_req_ready", 32'(req_ready), 32'd0);
      end
      resp_ready = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0;
      check_eq("post_hs_req_ready", 32'(req_ready), 32'd1);
    end else begin
      @(posedge clk); #1;
    end
    check_eq("post_hs_valid", 32'(resp_valid), 32'd0);
  endtask

  initial begin
    logic [31:0] rd, a, wd;
    logic        er, we;
    logic [2:0]  f3;

    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    check_eq("rst_req_ready", 32'(req_ready), 32'd1);
    check_eq("rst_resp_valid", 32'(resp_valid), 32'd0);
    check_eq("rst_rdata", resp_rdata, 32'd0);
    check_eq("rst_err", 32'(resp_err), 32'd0);

    do_txn(1, 3'd2, 32'h10, 32'hDEAD_BEEF, 32'd0, 0, 0);
    do_txn(0, 3'd2, 32'h10, 32'd0, 32'hDEAD_BEEF, 0, 0);

    do_txn(1, 3'd2, 32'h20, 32'd0, 32'd0, 0, 0);
    do_txn(1, 3'd0, 32'h21, 32'h80, 32'd0, 0, 0);
    do_txn(0, 3'd0, 32'h21, 32'd0, 32'hFFFF_FF80, 0, 0);
    do_txn(0, 3'd4, 32'h21, 32'd0, 32'h0000_0080, 0, 0);
    do_txn(0, 3'd2, 32'h20, 32'd0, 32'h0000_8000, 0, 0);

    do_txn(1, 3'd2, 32'h20, 32'h8001_1234, 32'd0, 0, 0);
    do_txn(0, 3'd1, 32'h22, 32'd0, 32'hFFFF_8001, 0, 0);
    do_txn(0, 3'd5, 32'h22, 32'd0, 32'h0000_8001, 0, 0);
    do_txn(0, 3'd1, 32'h20, 32'd0, 32'h0000_1234, 0, 0);

    do_txn(0, 3'd2, 32'h20, 32'd0, 32'h8001_1234, 0, 5);
    do_txn(0, 3'd2, 32'h10, 32'd0, 32'hDEAD_BEEF, 0, 0);

    do_txn(1, 3'd2, 32'h10, 32'h1111_1111, 32'd0, 0, 0);
    do_txn(1, 3'd2, 32'h13, 32'h2222_2222, 32'd0, TRAP, 0);
    do_txn(0, 3'd2, 32'h10, 32'd0, TRAP ? 32'h1111_1111 : 32'h2222_2222, 0, 0);
    do_txn(0, 3'd3, 32'h10, 32'd0, 32'd0, 1, 0);
    do_txn(1, 3'd3, 32'h10, 32'h3333_3333, 32'd0, 1, 0);
    do_txn(0, 3'd2, 32'h10, 32'd0, TRAP ? 32'h1111_1111 : 32'h2222_2222, 0, 0);

    do_txn(1, 3'd2, 32'h400, 32'hA5A5_A5A5, 32'd0, 0, 0);
    do_txn(0, 3'd2, 32'h000, 32'd0, 32'hA5A5_A5A5, 0, 0);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'd2; req_addr = 32'h0; req_wdata = 32'h5A5A_5A5A;
    @(posedge clk); #1;
    req_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    check_eq("abort_req_ready", 32'(req_ready), 32'd1);
    check_eq("abort_resp_valid", 32'(resp_valid), 32'd0);
    repeat (3) begin
      @(posedge clk); #1;
      check_eq("abort_no_resp", 32'(resp_valid), 32'd0);
    end
    do_txn(0, 3'd2, 32'h000, 32'd0, 32'hA5A5_A5A5, 0, 0);

    for (int i = 0; i < 16; i++) begin
      wd = $urandom;
      model_op(1'b1, 3'd2, 32'h40 + 32'(4*i), wd, rd, er);
      do_txn(1, 3'd2, 32'h40 + 32'(4*i), wd, rd, er, 0);
    end
    for (int i = 0; i < 40; i++) begin
      we = 1'($urandom_range(0, 1));
      f3 = 3'($urandom_range(0, 7));
      a  = 32'h40 + 32'($urandom_range(0, 63));
      wd = $urandom;
      model_op(we, f3, a, wd, rd, er);
      do_txn(we, f3, a, wd, rd, er, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
